// File: rtl/sap1_pkg.sv
// ============================================================================
// Module      : sap1_pkg
// Description : Shared widths, opcode encoding and sizing helper for the
//               SAP-1 instruction prefetch path.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sap1_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int OPC_W_DEF  = 4;

    typedef enum logic [3:0] {
        LDA = 4'h0,
        ADD = 4'h1,
        SUB = 4'h2,
        OUT = 4'hE,
        HLT = 4'hF
    } opcode_e;

    // Occupancy counter needs one extra bit so that DEPTH itself is representable.
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ir_fifo_mem.sv
// ============================================================================
// Module      : ir_fifo_mem
// Description : DEPTH x WIDTH register array, one write port and one
//               asynchronous read port; storage is intentionally not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_fifo_mem #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [WIDTH-1:0]         rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

`default_nettype wire

// File: rtl/ir_prefetch_queue.sv
// ============================================================================
// Module      : ir_prefetch_queue
// Description : DEPTH-entry instruction prefetch queue; head entry is split
//               into opcode/operand. Optional macro IR_PARITY_EN adds a
//               per-entry even-parity bit and head parity checking.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ir_prefetch_queue
    import sap1_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int OPC_W  = OPC_W_DEF,
    parameter int DEPTH  = 4
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          Li,
    input  logic                          Ei,
    input  logic                          adv,
    input  logic                          flush,
    input  logic [DATA_W-1:0]             ir_in,
    output logic [DATA_W-1:0]             ir_val,
    output logic [OPC_W-1:0]              opcode,
    output logic [DATA_W-OPC_W-1:0]       ir_out,
    output logic                          ir_valid,
    output logic                          full,
    output logic [count_width(DEPTH)-1:0] count,
    output logic                          ovf,
    output logic                          par_err
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = count_width(DEPTH);
`ifdef IR_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    logic              ovf_set;
    logic [MEM_W-1:0]  wr_word;
    logic [MEM_W-1:0]  rd_word;
    logic [DATA_W-1:0] head_word;

    assign ir_valid = (count != '0);
    assign full     = (count == CW'(DEPTH));
    assign pop      = adv & ir_valid;
    // A pop frees a slot in the same edge, so a full queue may still accept.
    assign push     = ~Li & (~full | pop);
    assign ovf_set  = ~Li & full & ~pop;

`ifdef IR_PARITY_EN
    logic head_par;
    assign wr_word  = {^ir_in, ir_in};
    assign head_par = rd_word[DATA_W];
    assign par_err  = ir_valid & ((^ir_val) != head_par);
`else
    assign wr_word  = ir_in;
    assign par_err  = 1'b0;
`endif

    assign head_word = rd_word[DATA_W-1:0];

    ir_fifo_mem #(
        .WIDTH (MEM_W),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk     (CLK),
        .we      (push & ~flush),
        .wr_addr (wr_ptr),
        .wr_data (wr_word),
        .rd_addr (rd_ptr),
        .rd_data (rd_word)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
            if (ovf_set) begin
                ovf <= 1'b1;
            end
        end
    end

    assign ir_val = ir_valid ? head_word : '0;
    assign opcode = ir_val[DATA_W-1 -: OPC_W];
    assign ir_out = ~Ei ? ir_val[DATA_W-OPC_W-1:0] : '0;

endmodule

`default_nettype wire

// File: tb/tb_ir_prefetch_queue.sv
// ============================================================================
// Module      : tb_ir_prefetch_queue
// Description : Directed self-checking bench for ir_prefetch_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ir_prefetch_queue;

    logic       CLK;
    logic       RST;
    logic       Li;
    logic       Ei;
    logic       adv;
    logic       flush;
    logic [7:0] ir_in;
    logic [7:0] ir_val;
    logic [3:0] opcode;
    logic [3:0] ir_out;
    logic       ir_valid;
    logic       full;
    logic [2:0] count;
    logic       ovf;
    logic       par_err;

    int checks;
    int errors;

    ir_prefetch_queue #(
        .DATA_W (8),
        .OPC_W  (4),
        .DEPTH  (4)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .Li       (Li),
        .Ei       (Ei),
        .adv      (adv),
        .flush    (flush),
        .ir_in    (ir_in),
        .ir_val   (ir_val),
        .opcode   (opcode),
        .ir_out   (ir_out),
        .ir_valid (ir_valid),
        .full     (full),
        .count    (count),
        .ovf      (ovf),
        .par_err  (par_err)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input logic [7:0] w);
        Li = 1'b0;
        ir_in = w;
        step();
        Li = 1'b1;
    endtask

    task automatic pop_one();
        adv = 1'b1;
        step();
        adv = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; Li = 1'b1; Ei = 1'b1; adv = 1'b0; flush = 1'b0; ir_in = 8'h00;
        #1;
        checks++;
        if (count !== 3'd0 || ir_valid !== 1'b0 || ir_val !== 8'h00 || ovf !== 1'b0 || full !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d valid=%b val=%h ovf=%b full=%b expected 0 0 00 0 0",
                     count, ir_valid, ir_val, ovf, full);
        end
        checks++;
        if (par_err !== 1'b0 || opcode !== 4'h0 || ir_out !== 4'h0) begin
            errors++;
            $display("FAIL reset_outputs: par_err=%b opcode=%h ir_out=%h expected 0 0 0", par_err, opcode, ir_out);
        end
        #11 RST = 1'b0;
        step();
    endtask

    task automatic test_load_split();
        push(8'h1A);
        checks++;
        if (ir_valid !== 1'b1 || opcode !== 4'h1 || ir_out !== 4'h0 || count !== 3'd1) begin
            errors++;
            $display("FAIL load_split: valid=%b opcode=%h ir_out=%h count=%0d expected 1 1 0 1",
                     ir_valid, opcode, ir_out, count);
        end
        Ei = 1'b0;
        #1;
        checks++;
        if (ir_out !== 4'hA) begin
            errors++;
            $display("FAIL operand_enable: ir_out=%h expected a", ir_out);
        end
        Ei = 1'b1;
        pop_one();
        checks++;
        if (count !== 3'd0 || ir_val !== 8'h00 || ir_valid !== 1'b0) begin
            errors++;
            $display("FAIL pop_to_empty: count=%0d val=%h valid=%b expected 0 00 0", count, ir_val, ir_valid);
        end
    endtask

    task automatic test_fill_overflow();
        push(8'h0F);
        push(8'h1E);
        push(8'h2D);
        push(8'hE0);
        checks++;
        if (full !== 1'b1 || count !== 3'd4 || ovf !== 1'b0 || ir_val !== 8'h0F) begin
            errors++;
            $display("FAIL fill: full=%b count=%0d ovf=%b head=%h expected 1 4 0 0f", full, count, ovf, ir_val);
        end
        push(8'hF0);
        checks++;
        if (ovf !== 1'b1 || count !== 3'd4 || ir_val !== 8'h0F) begin
            errors++;
            $display("FAIL overflow: ovf=%b count=%0d head=%h expected 1 4 0f", ovf, count, ir_val);
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] exp_heads [3];
        exp_heads[0] = 8'h2D;
        exp_heads[1] = 8'hE0;
        exp_heads[2] = 8'hF0;
        Li = 1'b0; adv = 1'b1; ir_in = 8'hF0;
        step();
        Li = 1'b1; adv = 1'b0;
        checks++;
        if (count !== 3'd4 || ir_val !== 8'h1E || ovf !== 1'b1 || full !== 1'b1) begin
            errors++;
            $display("FAIL push_pop_full: count=%0d head=%h ovf=%b full=%b expected 4 1e 1 1", count, ir_val, ovf, full);
        end
        for (int i = 0; i < 3; i++) begin
            pop_one();
            checks++;
            if (ir_val !== exp_heads[i] || count !== 3'(3 - i)) begin
                errors++;
                $display("FAIL drain_%0d: head=%h count=%0d expected %h %0d", i, ir_val, count, exp_heads[i], 3 - i);
            end
        end
    endtask

    task automatic test_push_pop_empty();
        pop_one();
        Li = 1'b0; adv = 1'b1; ir_in = 8'h33;
        step();
        Li = 1'b1; adv = 1'b0;
        checks++;
        if (count !== 3'd1 || ir_val !== 8'h33 || ovf !== 1'b1) begin
            errors++;
            $display("FAIL push_pop_empty: count=%0d head=%h ovf=%b expected 1 33 1", count, ir_val, ovf);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] words [3];
        words[0] = 8'h24;
        words[1] = 8'hE5;
        words[2] = 8'hF6;
        for (int i = 0; i < 3; i++) begin
            Li = 1'b0; adv = 1'b1; ir_in = words[i];
            step();
            checks++;
            if (ir_val !== words[i] || count !== 3'd1) begin
                errors++;
                $display("FAIL back_to_back_%0d: head=%h count=%0d expected %h 1", i, ir_val, count, words[i]);
            end
        end
        Li = 1'b1; adv = 1'b0;
    endtask

    task automatic test_flush();
        push(8'h44);
        push(8'h55);
        flush = 1'b1; Li = 1'b0; ir_in = 8'h66;
        step();
        flush = 1'b0; Li = 1'b1;
        checks++;
        if (count !== 3'd0 || ir_valid !== 1'b0 || ir_val !== 8'h00 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL flush: count=%0d valid=%b val=%h ovf=%b expected 0 0 00 0", count, ir_valid, ir_val, ovf);
        end
        push(8'h21);
        checks++;
        if (ir_val !== 8'h21 || count !== 3'd1) begin
            errors++;
            $display("FAIL after_flush: head=%h count=%0d expected 21 1", ir_val, count);
        end
        pop_one();
    endtask

    task automatic test_async_reset();
        push(8'h12);
        push(8'h34);
        checks++;
        if (count !== 3'd2 || ir_val !== 8'h12) begin
            errors++;
            $display("FAIL pre_reset: count=%0d head=%h expected 2 12", count, ir_val);
        end
        #2 RST = 1'b1;
        #1;
        checks++;
        if (count !== 3'd0 || ir_val !== 8'h00 || ir_valid !== 1'b0 || opcode !== 4'h0) begin
            errors++;
            $display("FAIL async_reset: count=%0d val=%h valid=%b opcode=%h expected 0 00 0 0",
                     count, ir_val, ir_valid, opcode);
        end
        #1 RST = 1'b0;
        pop_one();
        checks++;
        if (count !== 3'd0 || ir_valid !== 1'b0 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL adv_empty: count=%0d valid=%b ovf=%b expected 0 0 0", count, ir_valid, ovf);
        end
    endtask

    task automatic test_parity();
        push(8'h37);
        checks++;
        if (par_err !== 1'b0 || ir_val !== 8'h37) begin
            errors++;
            $display("FAIL parity_clean: par_err=%b head=%h expected 0 37", par_err, ir_val);
        end
`ifdef IR_PARITY_EN
        force dut.head_par = 1'b0;
        #1;
        checks++;
        if (par_err !== 1'b1) begin
            errors++;
            $display("FAIL parity_corrupt: par_err=%b expected 1", par_err);
        end
        release dut.head_par;
        #1;
`endif
        pop_one();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_load_split();
        test_fill_overflow();
        test_push_pop_full();
        test_push_pop_empty();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_parity();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
